// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver for the countdown timer.
// Frame-coherent digit snapshot, dead time, zero blanking, MM.SS point, blink.
module seg7_scan #(
  parameter int REFRESH_BITS = 16,
  parameter int DEAD_CYCLES  = 64,
  parameter int BLINK_BITS   = 26,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bin0,
  input  logic [3:0] bin1,
  input  logic [3:0] bin2,
  input  logic [3:0] bin3,
  input  logic       expired,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam logic [REFRESH_BITS-1:0] DEAD =
    REFRESH_BITS'(DEAD_CYCLES);

  logic [REFRESH_BITS-1:0] slot_cnt;
  logic [1:0]              idx;
  logic [3:0][3:0]         sh;
  logic [BLINK_BITS-1:0]   blink_cnt;

  logic       slot_end;
  logic       lz_blank;
  logic       blank;
  logic [3:0] cur;
  logic [6:0] glyph;

  always_comb begin
    slot_end = &slot_cnt;
    cur      = sh[idx];
    lz_blank = BLANK_LZ && (idx == 2'd3) && (sh[3] == 4'd0);
    blank    = (slot_cnt < DEAD) || blink_cnt[BLINK_BITS-1] || lz_blank;
  end

  always_comb begin
    glyph = 7'h3F;
    unique case (cur)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_end)
        idx <= idx + 2'd1;
    end
  end

  // Capture only at the very end of digit 3 so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sh <= '0;
    else if (slot_end && idx == 2'd3)
      sh <= {bin3, bin2, bin1, bin0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      blink_cnt <= '0;
    else if (expired)
      blink_cnt <= blink_cnt + 1'b1;
    else
      blink_cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else if (blank) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= glyph;
      dp  <= (idx != 2'd2);
      an  <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed phases plus random digits/expiry,
// checked against a cycle-count reference model.
module tb_seg7_scan;

  localparam int RB = 2;
  localparam int DC = 1;
  localparam int BB = 3;
  localparam int SLOT = 1 << RB;
  localparam int FRAME = 4 * SLOT;
  localparam int HALF = 1 << (BB - 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic       expired = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;

  int checks = 0;
  int failures = 0;

  int n;
  int run;
  int snap[4];

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_BITS(RB), .DEAD_CYCLES(DC),
              .BLINK_BITS(BB), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .reset(reset),
    .bin0(b0), .bin1(b1), .bin2(b2), .bin3(b3),
    .expired(expired),
    .seg(seg_a), .dp(dp_a), .an(an_a)
  );

  seg7_scan #(.REFRESH_BITS(RB), .DEAD_CYCLES(DC),
              .BLINK_BITS(BB), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .reset(reset),
    .bin0(b0), .bin1(b1), .bin2(b2), .bin3(b3),
    .expired(expired),
    .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  function automatic logic [6:0] glyph(int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    run = 0;
    for (int i = 0; i < 4; i++) snap[i] = 0;
  endtask

  // One clock: predict outputs from elapsed cycles, then check.
  task automatic tick();
    int slot, d;
    bit off, bl_a, bl_b;
    logic [6:0] es_a, es_b;
    logic ed_a, ed_b;
    logic [3:0] ea_a, ea_b, onehot;
    slot = n % SLOT;
    d = (n / SLOT) % 4;
    off = (run % (2 * HALF)) >= HALF;
    bl_b = (slot < DC) || off;
    bl_a = bl_b || (d == 3 && snap[3] == 0);
    onehot = 4'hF;
    onehot[d] = 1'b0;
    es_a = bl_a ? 7'h7F : glyph(snap[d]);
    es_b = bl_b ? 7'h7F : glyph(snap[d]);
    ed_a = bl_a ? 1'b1 : (d != 2);
    ed_b = bl_b ? 1'b1 : (d != 2);
    ea_a = bl_a ? 4'hF : onehot;
    ea_b = bl_b ? 4'hF : onehot;
    if (n % FRAME == FRAME - 1) begin
      snap[0] = int'(b0);
      snap[1] = int'(b1);
      snap[2] = int'(b2);
      snap[3] = int'(b3);
    end
    run = expired ? run + 1 : 0;
    n++;
    @(posedge clk);
    #1;
    chk("seg_lz", {1'b0, seg_a}, {1'b0, es_a});
    chk("dp_lz", {7'b0, dp_a}, {7'b0, ed_a});
    chk("an_lz", {4'b0, an_a}, {4'b0, ea_a});
    chk("seg_nolz", {1'b0, seg_b}, {1'b0, es_b});
    chk("dp_nolz", {7'b0, dp_b}, {7'b0, ed_b});
    chk("an_nolz", {4'b0, an_b}, {4'b0, ea_b});
  endtask

  task automatic run_to(int target);
    while (n < target) tick();
  endtask

  initial begin
    int blanks;
    model_reset();

    // 1: reset state, then first frame of zeros
    @(posedge clk);
    #1;
    chk("rst_an", {4'b0, an_a}, 8'h0F);
    chk("rst_seg", {1'b0, seg_a}, 8'h7F);
    chk("rst_dp", {7'b0, dp_a}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("first_dead", {4'b0, an_a}, 8'h0F);
    tick();
    chk("first_d0_seg", {1'b0, seg_a}, 8'h40);
    chk("first_d0_an", {4'b0, an_a}, 8'h0E);
    run_to(10);
    chk("first_d2_dp", {7'b0, dp_a}, 8'h00);
    run_to(14);
    chk("first_d3_blank", {4'b0, an_a}, 8'h0F);

    // 2/3: 01:59, shown from the frame after the next snapshot
    run_to(16);
    b0 = 4'd9; b1 = 4'd5; b2 = 4'd1; b3 = 4'd0;
    run_to(34);
    chk("d0_9", {1'b0, seg_a}, 8'h10);
    run_to(38);
    chk("d1_5", {1'b0, seg_a}, 8'h12);
    run_to(42);
    chk("d2_1", {1'b0, seg_a}, 8'h79);
    chk("d2_dp", {7'b0, dp_a}, 8'h00);
    run_to(46);
    chk("d3_lz_an", {4'b0, an_a}, 8'h0F);
    chk("d3_nolz_an", {4'b0, an_b}, 8'h07);
    chk("d3_nolz_seg", {1'b0, seg_b}, 8'h40);

    // 4: change inputs while idx==1
    run_to(52);
    b0 = 4'd3; b1 = 4'd2; b2 = 4'd4; b3 = 4'd1;
    run_to(58);
    chk("tear_d2", {1'b0, seg_a}, 8'h79);
    run_to(66);
    chk("new_d0", {1'b0, seg_a}, 8'h30);

    // 5: invalid BCD, then blink on expiry
    b1 = 4'hC;
    run_to(80);
    run_to(86);
    chk("dash", {1'b0, seg_a}, 8'h3F);
    expired = 1'b1;
    tick();
    blanks = 0;
    for (int i = 0; i < 2 * HALF; i++) begin
      tick();
      if (seg_b == 7'h7F && an_b == 4'hF) blanks++;
    end
    checks++;
    assert (blanks >= HALF) else begin
      failures++;
      $error("FAIL blink_off got=%0d want>=%0d", blanks, HALF);
    end
    for (int i = 0; i < 20; i++) tick();
    expired = 1'b0;
    for (int i = 0; i < 24; i++) tick();

    // random digits and expiry bursts
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        b0 = 4'($urandom_range(0, 15));
        b1 = 4'($urandom_range(0, 15));
        b2 = 4'($urandom_range(0, 15));
        b3 = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) == 0) expired = ~expired;
      tick();
    end

    // 6: async reset mid-slot
    expired = 1'b0;
    b3 = 4'd2;
    run_to(((n / FRAME) + 3) * FRAME + 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_an", {4'b0, an_a}, 8'h0F);
    chk("async_seg", {1'b0, seg_a}, 8'h7F);
    chk("async_dp", {7'b0, dp_a}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_to(2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
